// File: rtl/qspi_flash_reader.sv
// qspi_flash_reader: word read engine behind the flash cache. Issues a Quad
// Output Fast Read (serial command/address on IO0, 4-bit data), rebuilds
// 32-bit little-endian words and keeps streaming while the requester asks for
// consecutive words, without sending a new command.
module qspi_flash_reader #(
  parameter logic [7:0]  READ_COMMAND   = 8'h6B,
  parameter int unsigned DUMMY_CYCLES   = 8,
  parameter int unsigned CS_HIGH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] dataRequest_address,
  input  logic        dataRequest_enable,
  output logic [31:0] dataRequest_data,
  output logic        dataRequest_dataValid,
  output logic        flash_csb,
  output logic        flash_sck,
  output logic [3:0]  flash_io_out,
  output logic [3:0]  flash_io_oe,
  input  logic [3:0]  flash_io_in
);

  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HIGH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_VALID, S_DECIDE, S_HOLD
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;      // SCK periods in CMD/ADDR/DUMMY/DATA, clk cycles in HOLD
  logic [21:0] addr_q;     // word address of the word currently being read
  logic [30:0] sh_q;       // command/address bits still to be sent on IO0
  logic [31:0] word_q;     // nibbles collected so far for the current word
  logic [31:0] data_q;
  logic        valid_q;
  logic        csb_q;
  logic        sck_q;
  logic [3:0]  io_out_q;
  logic [3:0]  io_oe_q;

  logic [21:0] next_word_d;
  logic        cont_d;
  logic [4:0]  nib_pos_d;
  logic [31:0] word_d;

  // Byte address bits [1:0] are forced to zero on the bus and never used.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^dataRequest_address[1:0];

  // Continuation test and placement of the incoming nibble in the word.
  always_comb begin
    next_word_d = addr_q + 22'd1;
    cont_d      = dataRequest_enable
                  && (dataRequest_address[23:2] == next_word_d)
                  && (addr_q != 22'h3FFFFF);
    // Nibble k lands in byte k/2; even k is the high nibble.
    nib_pos_d   = {cnt_q[2:1], ~cnt_q[0], 2'b00};
    word_d      = word_q;
    word_d[nib_pos_d +: 4] = flash_io_in;
  end

  // Transaction FSM; every pad and handshake output is a register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      sh_q     <= '0;
      word_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      csb_q    <= 1'b1;
      sck_q    <= 1'b0;
      io_out_q <= 4'b0000;
      io_oe_q  <= 4'b0000;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          csb_q    <= 1'b1;
          sck_q    <= 1'b0;
          io_out_q <= 4'b0000;
          io_oe_q  <= 4'b0000;
          if (dataRequest_enable) begin
            addr_q   <= dataRequest_address[23:2];
            // First command bit goes out with CS; the rest wait in sh_q.
            io_out_q <= {3'b000, READ_COMMAND[7]};
            sh_q     <= {READ_COMMAND[6:0], dataRequest_address[23:2], 2'b00};
            io_oe_q  <= 4'b0001;
            csb_q    <= 1'b0;
            cnt_q    <= '0;
            state_q  <= S_CMD;
          end
        end

        S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
          if (!dataRequest_enable) begin
            // Abort: release the flash, no word is delivered.
            state_q  <= S_HOLD;
            cnt_q    <= '0;
            csb_q    <= 1'b1;
            sck_q    <= 1'b0;
            io_out_q <= 4'b0000;
            io_oe_q  <= 4'b0000;
          end else if (!sck_q) begin
            sck_q <= 1'b1;
          end else begin
            // End of the high phase: SCK falls, outputs advance, input sampled.
            sck_q <= 1'b0;
            cnt_q <= cnt_q + 8'd1;
            case (state_q)
              S_CMD, S_ADDR: begin
                if (cnt_q == 8'd31) begin
                  state_q  <= S_DUMMY;
                  cnt_q    <= '0;
                  io_out_q <= 4'b0000;
                  io_oe_q  <= 4'b0000;
                end else begin
                  io_out_q <= {3'b000, sh_q[30]};
                  sh_q     <= {sh_q[29:0], 1'b0};
                  if (cnt_q == 8'd7) state_q <= S_ADDR;
                end
              end
              S_DUMMY: begin
                if (cnt_q == DUMMY_LAST) begin
                  state_q <= S_DATA;
                  cnt_q   <= '0;
                end
              end
              default: begin
                word_q <= word_d;
                if (cnt_q == 8'd7) begin
                  data_q  <= word_d;
                  valid_q <= 1'b1;
                  state_q <= S_VALID;
                  cnt_q   <= '0;
                end
              end
            endcase
          end
        end

        S_VALID: state_q <= S_DECIDE;

        S_DECIDE: begin
          if (cont_d) begin
            // The flash keeps streaming the next bytes; just clock them in.
            addr_q  <= dataRequest_address[23:2];
            cnt_q   <= '0;
            state_q <= S_DATA;
          end else begin
            cnt_q   <= '0;
            csb_q   <= 1'b1;
            state_q <= S_HOLD;
          end
        end

        S_HOLD: begin
          csb_q <= 1'b1;
          sck_q <= 1'b0;
          if (cnt_q == HOLD_LAST) state_q <= S_IDLE;
          else cnt_q <= cnt_q + 8'd1;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dataRequest_data      = data_q;
  assign dataRequest_dataValid = valid_q;
  assign flash_csb             = csb_q;
  assign flash_sck             = sck_q;
  assign flash_io_out          = io_out_q;
  assign flash_io_oe           = io_oe_q;

endmodule
